// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types: the M-extension operation code and small
// classification helpers used by the multiply/divide execution unit.
package pipeline_types_pkg;

  // RV32M funct3 ordering, so the decoder can pass funct3 straight through.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_code_e;

  function automatic logic is_div(input muldiv_code_e code);
    return code inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_code_e code);
    return code inside {MD_REM, MD_REMU};
  endfunction

  // rs1 is treated as two's complement for these codes.
  function automatic logic op1_signed(input muldiv_code_e code);
    return code inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is treated as two's complement for these codes (MULHSU excluded).
  function automatic logic op2_signed(input muldiv_code_e code);
    return code inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational STEP-bit iteration of the shared multiply/divide datapath.
// acc holds {hi, lo}. Multiply: shift-add, hi accumulates the partial
// product, lo shifts out multiplier bits. Divide: restoring, hi is the
// partial remainder, lo shifts dividend bits out and quotient bits in.
module muldiv_step #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   acc_in,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   acc_out
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     wide;
  logic [XLEN:0]     diff;

  // Unrolled STEP iterations of add-and-shift or subtract-and-shift.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch;
    // blocking assignments are intentional here, each unrolled iteration
    // must see the value produced by the previous one.
    acc  = acc_in;
    wide = '0;
    diff = '0;
    for (int i = 0; i < STEP; i++) begin
      if (is_div) begin
        // Shift the next dividend bit into the remainder and trial-subtract.
        wide = acc[2*XLEN-1:XLEN-1];
        diff = wide - {1'b0, operand};
        if (!diff[XLEN]) acc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else             acc = {wide[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        // Add the multiplicand when the current multiplier bit is set,
        // then shift the carry-extended sum right by one.
        wide = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        acc  = {wide, acc[XLEN-1:1]};
      end
    end
    acc_out = acc;
  end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M multiply/divide execution unit. Operates on operand
// magnitudes, retiring STEP bits per cycle, with special-case fast paths
// (divide by zero, signed overflow) and final sign correction done here.
module exec_muldiv_unit
  import pipeline_types_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEP  = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int K     = XLEN / STEP;
  localparam int CNT_W = $clog2(K) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  muldiv_code_e      code_q;
  logic              neg_q;
  logic              fast_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opd_q;

  muldiv_code_e      code_in;
  logic              accept;
  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic              neg_in;

  logic [2*XLEN-1:0] acc_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   final_res;

  assign code_in  = muldiv_code_e'(in_code);
  assign busy     = (state != S_IDLE);
  assign in_ready = !rst && !flush &&
                    ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Accept-time decode: operand magnitudes, result sign and fast-path cases.
  always_comb begin
    s1          = op1_signed(code_in) && in_op1[XLEN-1];
    s2          = op2_signed(code_in) && in_op2[XLEN-1];
    mag1        = s1 ? -in_op1 : in_op1;
    mag2        = s2 ? -in_op2 : in_op2;
    div_zero    = is_div(code_in) && (in_op2 == '0);
    div_ovf     = (code_in inside {MD_DIV, MD_REM}) &&
                  (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_op2 == '1);
    // Remainder follows the dividend's sign; product/quotient follow s1^s2.
    neg_in      = is_rem(code_in) ? s1 : (s1 ^ s2);
    special_res = '0;
    if (div_zero)     special_res = is_rem(code_in) ? in_op1 : '1;
    else if (div_ovf) special_res = is_rem(code_in) ? '0 : in_op1;
  end

  muldiv_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .is_div  (is_div(code_q)),
    .acc_in  (acc_q),
    .operand (opd_q),
    .acc_out (acc_nx)
  );

  // Sign correction and half selection applied to the final iteration output.
  always_comb begin
    prod    = neg_q ? -acc_nx : acc_nx;
    div_raw = is_rem(code_q) ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    if (is_div(code_q))        final_res = neg_q ? -div_raw : div_raw;
    else if (code_q == MD_MUL) final_res = prod[XLEN-1:0];
    else                       final_res = prod[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers; flush outranks any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      code_q     <= MD_MUL;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      acc_q      <= '0;
      opd_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Covers both a fresh accept in IDLE and a zero-bubble accept in DONE.
      state     <= S_CALC;
      cnt       <= '0;
      code_q    <= code_in;
      neg_q     <= neg_in;
      fast_q    <= div_zero || div_ovf;
      acc_q     <= {{XLEN{1'b0}}, mag1};
      opd_q     <= mag2;
      out_tag   <= in_tag;
      out_valid <= 1'b0;
      if (div_zero || div_ovf) out_result <= special_res;
    end else begin
      case (state)
        S_CALC: begin
          if (fast_q) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            acc_q <= acc_nx;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(K - 1)) begin
              state      <= S_DONE;
              out_valid  <= 1'b1;
              out_result <= final_res;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed testbench for exec_muldiv_unit: a STEP=1 instance is the main
// target; a STEP=4 instance shares the same stimulus for the latency rerun.
module tb_exec_muldiv_unit;
  import pipeline_types_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [2:0]       in_code;
  logic [XLEN-1:0]  in_op1, in_op2;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready,  out_valid,  busy;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             in_ready4, out_valid4, busy4;
  logic [XLEN-1:0]  out_result4;
  logic [TAG_W-1:0] out_tag4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_muldiv_unit #(.XLEN(XLEN), .STEP(1), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  exec_muldiv_unit #(.XLEN(XLEN), .STEP(4), .TAG_W(TAG_W)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_code(in_code),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_result(out_result4), .out_tag(out_tag4), .busy(busy4)
  );

  // Present a request at a negedge; returns in_ready as seen before the edge.
  task automatic send_req(input logic [2:0] code, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                          output logic rdy);
    @(negedge clk);
    in_code  = code;
    in_op1   = a;
    in_op2   = b;
    in_tag   = tag;
    in_valid = 1'b1;
    rdy      = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the accept edge; counts edges including the
  // accept edge until out_valid is seen, bounded by a cycle budget.
  task automatic wait_done(input bit use4, output int edges, output bit got);
    edges = 1;
    got   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((use4 ? out_valid4 : out_valid) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_code = '0; in_op1 = '0; in_op2 = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready, out_result, out_tag} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b b=%b r=%b res=%h tag=%h, expected all 0",
               out_valid, busy, in_ready, out_result, out_tag);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  // Generic directed-vector runner used by the mul and div feature tests.
  task automatic run_vectors(input string grp, input logic [2:0] code,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [TAG_W-1:0] tag,
                             input logic [XLEN-1:0] exp, input int exp_edges);
    logic rdy; int edges; bit got;
    send_req(code, a, b, tag, rdy);
    wait_done(1'b0, edges, got);
    checks++;
    if (rdy !== 1'b1 || !got) begin
      failures++;
      $display("FAIL %s_handshake code=%0d: ready=%b done=%b, expected 1/1", grp, code, rdy, got);
    end
    checks++;
    if (edges != exp_edges) begin
      failures++;
      $display("FAIL %s_latency code=%0d: got %0d edges expected %0d", grp, code, edges, exp_edges);
    end
    checks++;
    if (out_result !== exp || out_tag !== tag) begin
      failures++;
      $display("FAIL %s_result code=%0d a=%h b=%h: got %h/tag %h expected %h/tag %h",
               grp, code, a, b, out_result, out_tag, exp, tag);
    end
    handshake();
  endtask

  task automatic test_mul();
    run_vectors("mul",    MD_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_vectors("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
    run_vectors("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, 33);
    run_vectors("mulh",   MD_MULH,   32'h8000_0000, 32'd2,         5'd8,  32'hFFFF_FFFF, 33);
  endtask

  task automatic test_div();
    run_vectors("div",      MD_DIV,  32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33);
    run_vectors("rem",      MD_REM,  32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33);
    run_vectors("divu_z",   MD_DIVU, 32'd7,         32'd0,         5'd12, 32'hFFFF_FFFF, 2);
    run_vectors("remu_z",   MD_REMU, 32'd7,         32'd0,         5'd13, 32'd7,         2);
    run_vectors("rem_ovf",  MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         2);
    run_vectors("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2);
  endtask

  task automatic test_back_to_back();
    logic rdy; int edges; bit got; int bad;
    send_req(MD_DIVU, 32'd50, 32'd5, 5'd20, rdy);
    wait_done(1'b0, edges, got);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_result !== 32'd10 || out_tag !== 5'd20 || in_ready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (!got || bad != 0) begin
      failures++;
      $display("FAIL b2b_hold: done=%b unstable_cycles=%0d res=%h, expected 1/0/0000000a",
               got, bad, out_result);
    end
    in_code = MD_DIVU; in_op1 = 32'd100; in_op2 = 32'd7; in_tag = 5'd21;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_bubble: busy=%b valid=%b expected 1/0", busy, out_valid);
    end
    wait_done(1'b0, edges, got);
    checks++;
    if (!got || edges != 33 || out_result !== 32'd14 || out_tag !== 5'd21) begin
      failures++;
      $display("FAIL b2b_result: done=%b edges=%0d res=%h tag=%h expected 1/33/0000000e/15",
               got, edges, out_result, out_tag);
    end
    handshake();
  endtask

  task automatic test_flush();
    logic rdy; int seen;
    send_req(MD_MUL, 32'd3, 32'd4, 5'd1, rdy);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: busy=%b valid=%b expected 0/0", busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_no_output: out_valid high %0d cycles expected 0", seen);
    end
    in_code = MD_MUL; in_op1 = 32'd1; in_op2 = 32'd1; in_tag = 5'd2;
    in_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_with_req: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    logic rdy;
    send_req(MD_DIV, 32'd1000, 32'd3, 5'd3, rdy);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, out_result, out_tag} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: v=%b b=%b r=%b res=%h tag=%h expected all 0",
               out_valid, busy, in_ready, out_result, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    run_vectors("post_rst", MD_DIVU, 32'd100, 32'd7, 5'd4, 32'd14, 33);
  endtask

  task automatic test_step4();
    logic rdy; int edges4, edges; bit got4, got;
    send_req(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9, rdy);
    wait_done(1'b1, edges4, got4);
    checks++;
    if (!got4 || edges4 != 9) begin
      failures++;
      $display("FAIL step4_latency: done=%b edges=%0d expected 1/9", got4, edges4);
    end
    checks++;
    if (out_result4 !== 32'hFFFF_FFEB || out_tag4 !== 5'd9) begin
      failures++;
      $display("FAIL step4_result: got %h/tag %h expected ffffffeb/tag 09", out_result4, out_tag4);
    end
    wait_done(1'b0, edges, got);
    handshake();
    send_req(MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd22, rdy);
    wait_done(1'b1, edges4, got4);
    checks++;
    if (!got4 || out_result4 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL step4_rem: done=%b got %h expected ffffffff", got4, out_result4);
    end
    wait_done(1'b0, edges, got);
    handshake();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_step4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_muldiv_unit.md
EXEC_MULDIV_UNIT -- requirements
Module: exec_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits.
REQ-002 Parameter STEP, default 1, bits retired per iteration; legal values 1, 2 and 4; XLEN % STEP == 0.
REQ-003 Parameter TAG_W, default 5, width of the destination tag (rd address).
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 flush  in  1  kill in-flight op (branch mispredict/exception).
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  unit can accept a request this cycle.
REQ-009 in_code  in  3  MulDivCode: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (RV32M funct3 order).
REQ-010 in_op1, in_op2  in  XLEN  rs1/rs2 operands, already bypassed.
REQ-011 in_tag  in  TAG_W  destination tag, returned unchanged.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 out_result  out  XLEN  result; out_tag  out  TAG_W  tag of that result.
REQ-015 busy  out  1  high whenever state != IDLE.

Function
REQ-016 FSM states are IDLE, CALC and DONE; K = XLEN/STEP.
REQ-017 in_ready SHALL be high in IDLE, and in DONE while out_ready is high; it SHALL be low otherwise, and low whenever flush or rst is high.
REQ-018 Accept occurs on an edge with in_valid & in_ready; operands, code and tag are latched and the state goes to CALC.
REQ-019 CALC performs one STEP-bit iteration per edge; after the K-th iteration edge the state goes to DONE, so out_valid rises K+1 edges after the accept edge.
REQ-020 Multiply is shift-add over the |op| magnitudes into a 2*XLEN product, with operand signedness per code (MULHSU: op1 signed, op2 unsigned); the product is negated at the end when required; MUL returns the low half, MULH/MULHSU/MULHU return the high half.
REQ-021 Divide is restoring over magnitudes; quotient sign = sign(op1) xor sign(op2), remainder sign = sign(op1), for signed codes only.
REQ-022 Divide by zero takes the fast path: DONE after the accept+1 edge; quotient = all-ones and remainder = op1, for both signed and unsigned codes.
REQ-023 Signed overflow (op1 = 2^(XLEN-1), op2 = -1, DIV/REM) takes the fast path: quotient = op1, remainder = 0.
REQ-024 DONE holds out_result/out_tag stable until out_valid & out_ready.
REQ-025 On that handshake: the state goes to IDLE, or to CALC if a new request is accepted on the same edge (back-to-back, zero bubble).
REQ-026 flush SHALL force the state to IDLE on the next edge from any state, and out_valid SHALL drop after that edge.
REQ-027 A flush in the same cycle as the output handshake or an input request has priority: neither transfer occurs.
REQ-028 Iteration counter width is clog2(K)+1; it resets to 0 on accept and never wraps within an op.

Reset
REQ-029 While rst is high: state = IDLE, counter = 0, all datapath registers = 0, out_valid = 0, out_result = 0, out_tag = 0, busy = 0, in_ready = 0.
REQ-030 rst asserted mid-operation SHALL abandon the op with no output; the first accept is possible on the first edge after deassertion.

Structure
REQ-031 The MulDivCode typedef SHALL live in the shared PipelineTypes package; the FSM state enum is local to the module.
REQ-032 One sub-module, muldiv_step, SHALL hold the combinational STEP-bit iteration datapath (add/subtract-and-shift for both modes), instantiated once.
REQ-033 Special-case detection and final sign correction live in exec_muldiv_unit; a final correction register stage is optional, and if added the out_valid latency becomes K+2 (REQ-019 and the verification latencies change accordingly).

Verification
REQ-034 XLEN=32, STEP=1, MUL 7 x -3 -> out_result 0xFFFFFFEB, out_valid 33 edges after accept, tag echoed.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-036 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF at 2 edges; REM 0x80000000 / -1 -> 0.
REQ-037 out_ready held low 5 cycles in DONE: result stable and in_ready low; then a new DIVU 100/7 is accepted on the handshake edge -> 14 with no bubble.
REQ-038 flush at CALC iteration 10 -> IDLE next edge, no out_valid; flush together with in_valid -> request not accepted.
REQ-039 rst pulse mid-CALC -> all outputs 0 immediately; STEP=4 rerun of REQ-034 -> out_valid 9 edges after accept.
